instr_fetch: RTL

//   Fetch stage feeding the decode/control stage of the MIPS core. Owns the PC, issues in-order

---
 rtl/instr_fetch_pkg.sv | 34 +++
 rtl/instr_fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encodings, the nop word, the
// opcode/funct slice positions used by decode, and the branch target helper.
// Ports: none (package).
package instr_fetch_pkg;

   typedef enum logic [0:0] {
      FETCH_ST_RUN   = 1'b0,
      FETCH_ST_DRAIN = 1'b1
   } fetch_state_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;   // sll $0,$0,0

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   // Wide enough to count 0..8 buffer entries / outstanding reads.
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // beq-style target: pc + 4 + sign-extended word offset, mod 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [15:0] imm);
      logic [31:0] t;
      t = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
      return {t[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Purpose: synchronous FIFO of {pc,instr} entries with push/pop/clear and occupancy count.
// Latency: a push is visible at the head on the following cycle (registered storage).
// Backpressure: none internal; the caller's credit scheme guarantees no push when full.
// Ports: clk/rst; push + push_dat; pop; clear (drops all entries, wins over push/pop);
//        head_dat (oldest entry, undefined when count==0); count (entries held).
module instr_fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  fetch_entry_t     push_dat,
   input  logic             pop,
   input  logic             clear,
   output fetch_entry_t     head_dat,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is only looked at when count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Purpose: MIPS fetch stage - owns the PC, issues in-order imem reads, buffers words for decode.
// Latency: request accepted at N, response at N+k -> instr_valid at N+k+1.
// Backpressure: stall holds the head; requests stop once buffered + outstanding reaches FIFO_DEPTH.
// Ports: clk, rst (async, active high); imem_req_* (valid/ready/addr) and imem_rsp_* (valid/data)
//        to instruction memory; instr_valid/instr/instr_pc/opcode/funct to decode; stall,
//        redirect_valid, redirect_imm from control; perf_fetched/perf_squashed counters.
// Build option: define FETCH_PERF_EN to build the perf counters; otherwise perf_* read 0.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_imm,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
);

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] out_q, out_d;

   logic [CNT_W-1:0] fifo_cnt;
   fetch_entry_t     head;
   fetch_entry_t     push_dat;
   logic             head_vld;
   logic             consume, fire, req_vld, accept;
   logic             push, pop;
   logic [31:0]      rsp_pc;

   always_comb begin
      head_vld = (fifo_cnt != '0);
      consume  = head_vld & ~stall;
      fire     = consume & redirect_valid;

      // Credit check covers both buffered words and reads still in flight, so a
      // response can never find the FIFO full. Masked on fire so no request for
      // the wrong path can be accepted on a redirect cycle.
      req_vld = ~rst & (state_q == FETCH_ST_RUN) & ~fire &
                (({1'b0, fifo_cnt} + {1'b0, out_q}) < (CNT_W + 1)'(FIFO_DEPTH));
      accept  = req_vld & imem_req_ready;

      // Requests in flight are consecutive words ending just below pc_q, so the
      // oldest one (the one answering now) sits out_q words back.
      rsp_pc = pc_q - {{(30 - CNT_W){1'b0}}, out_q, 2'b00};

      push           = imem_rsp_valid & (state_q == FETCH_ST_RUN) & ~fire;
      push_dat.pc    = rsp_pc;
      push_dat.instr = imem_rsp_data;
      pop            = consume & ~fire;

      out_d = out_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

      pc_d = pc_q;
      if (fire)        pc_d = branch_target(head.pc, redirect_imm);
      else if (accept) pc_d = pc_q + 32'd4;

      state_d = state_q;
      case (state_q)
         FETCH_ST_RUN:   if (fire && (out_d != '0)) state_d = FETCH_ST_DRAIN;
         FETCH_ST_DRAIN: if (out_d == '0)           state_d = FETCH_ST_RUN;
         default:                                   state_d = FETCH_ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH_ST_RUN;
         pc_q    <= RESET_PC;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
      end
   end

   instr_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .clear    (fire),
      .head_dat (head),
      .count    (fifo_cnt)
   );

   assign imem_req_valid = req_vld;
   assign imem_req_addr  = req_vld ? pc_q : 32'h0;
   assign instr_valid    = head_vld;
   assign instr          = head_vld ? head.instr : INSTR_NOP;
   assign instr_pc       = head_vld ? head.pc : 32'h0;
   assign opcode         = instr[OPCODE_MSB:OPCODE_LSB];
   assign funct          = instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_squashed_q, perf_squashed_d;
   logic        rsp_drop;

   // The head of a fire is the branch itself and counts as fetched; only the
   // words behind it are squashed, along with any response that is not pushed.
   always_comb begin
      rsp_drop        = imem_rsp_valid & ~push;
      perf_fetched_d  = perf_fetched_q + 32'(consume);
      perf_squashed_d = perf_squashed_q + 32'(rsp_drop);
      if (fire) perf_squashed_d = perf_squashed_d + 32'(fifo_cnt) - 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q  <= '0;
         perf_squashed_q <= '0;
      end else begin
         perf_fetched_q  <= perf_fetched_d;
         perf_squashed_q <= perf_squashed_d;
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`else
   assign perf_fetched  = 32'h0;
   assign perf_squashed = 32'h0;
`endif

endmodule
